// File: rtl/synthetic2_flow_sequencer.sv
// Timed valve/device sequencer for the Planar_Synthetic_2 fluidic chain (transfer, optional temp wait, dwell per stage).
// Optional macro SYN2_SEQ_PAUSE_EN adds a pause input that freezes all timers and closes valves.
module synthetic2_flow_sequencer #(
   parameter int CNT_W         = 16,
   parameter int XFER_CYCLES   = 100,
   parameter int MIX_CYCLES    = 1000,
   parameter int HEAT_CYCLES   = 2000,
   parameter int FILTER_CYCLES = 500,
   parameter int TEMP_TIMEOUT  = 4000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        clr_err,
`ifdef SYN2_SEQ_PAUSE_EN
   input  logic        pause,
`endif
   input  logic [3:0]  heat_ready,
   output logic [10:0] valve_en,
   output logic [3:0]  mixer_en,
   output logic [3:0]  heater_en,
   output logic [1:0]  filter_en,
   output logic [3:0]  stage,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);
   // state     | meaning
   // IDLE      | waiting for start, stage parked at 0
   // XFER      | inlet valve of current stage open for XFER_CYCLES
   // WAIT_TEMP | heater on, waiting for heat_ready (bounded by TEMP_TIMEOUT)
   // DWELL     | stage device enabled for its dwell time
   // DONE      | one-cycle completion pulse
   // ERROR     | everything off, err_code held until clr_err

   typedef enum logic [2:0] {S_IDLE, S_XFER, S_WAIT_TEMP, S_DWELL, S_DONE, S_ERROR} state_t;
   typedef enum logic [1:0] {K_MIX, K_FILT, K_HEAT, K_OUT} kind_t;

   localparam logic [3:0]       LAST_STAGE  = 4'd10;
   localparam logic [1:0]       ERR_NONE    = 2'd0;
   localparam logic [1:0]       ERR_TIMEOUT = 2'd1;
   localparam logic [1:0]       ERR_ABORT   = 2'd2;
   localparam logic [CNT_W-1:0] XFER_LD     = CNT_W'(XFER_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIX_LD      = CNT_W'(MIX_CYCLES - 1);
   localparam logic [CNT_W-1:0] HEAT_LD     = CNT_W'(HEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILT_LD     = CNT_W'(FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] TEMP_LD     = CNT_W'(TEMP_TIMEOUT - 1);
   localparam longint           CNT_SPAN    = longint'(1) << CNT_W;

   if (XFER_CYCLES < 1 || MIX_CYCLES < 1 || HEAT_CYCLES < 1 ||
       FILTER_CYCLES < 1 || TEMP_TIMEOUT < 1) begin : g_bad_cycles
      $error("synthetic2_flow_sequencer: every *_CYCLES and TEMP_TIMEOUT must be >= 1");
   end
   if (longint'(XFER_CYCLES) > CNT_SPAN || longint'(MIX_CYCLES) > CNT_SPAN ||
       longint'(HEAT_CYCLES) > CNT_SPAN || longint'(FILTER_CYCLES) > CNT_SPAN ||
       longint'(TEMP_TIMEOUT) > CNT_SPAN) begin : g_bad_width
      $error("synthetic2_flow_sequencer: a cycle count does not fit in CNT_W bits");
   end

   function automatic kind_t stage_kind(input logic [3:0] s);
      case (s)
         4'd0, 4'd2, 4'd5, 4'd8: stage_kind = K_MIX;
         4'd1, 4'd6:             stage_kind = K_FILT;
         4'd3, 4'd4, 4'd7, 4'd9: stage_kind = K_HEAT;
         default:                stage_kind = K_OUT;
      endcase
   endfunction

   // Device index within its own enable bus (heaters are not in flow order).
   function automatic logic [1:0] dev_idx(input logic [3:0] s);
      case (s)
         4'd0, 4'd1, 4'd3: dev_idx = 2'd0;
         4'd2, 4'd6, 4'd7: dev_idx = 2'd1;
         4'd4, 4'd5:       dev_idx = 2'd2;
         default:          dev_idx = 2'd3;
      endcase
   endfunction

   state_t           state, state_n;
   logic [3:0]       stage_n;
   logic [CNT_W-1:0] cnt, cnt_n, dwell_ld;
   logic [1:0]       err_code_n;
   logic             frozen;
   logic [1:0]       cur_idx, nxt_idx;
   kind_t            cur_kind;
   logic [10:0]      valve_n;
   logic [3:0]       mixer_n, heater_n;
   logic [1:0]       filter_n;

`ifdef SYN2_SEQ_PAUSE_EN
   assign frozen = pause;
`else
   assign frozen = 1'b0;
`endif

   assign cur_kind = stage_kind(stage);
   assign cur_idx  = dev_idx(stage);
   assign nxt_idx  = dev_idx(stage_n);

   always_comb begin
      case (cur_kind)
         K_MIX:   dwell_ld = MIX_LD;
         K_FILT:  dwell_ld = FILT_LD;
         default: dwell_ld = HEAT_LD;
      endcase
   end

   always_comb begin
      state_n    = state;
      stage_n    = stage;
      cnt_n      = cnt;
      err_code_n = err_code;
      case (state)
         S_IDLE: begin
            stage_n = '0;
            if (start) begin
               state_n = S_XFER;
               cnt_n   = XFER_LD;
            end
         end
         S_XFER: begin
            if (abort) begin
               state_n    = S_ERROR;
               err_code_n = ERR_ABORT;
            end else if (!frozen) begin
               if (cnt != '0) begin
                  cnt_n = cnt - CNT_W'(1);
               end else if (stage == LAST_STAGE) begin
                  state_n = S_DONE;
               end else if (cur_kind == K_HEAT) begin
                  state_n = S_WAIT_TEMP;
                  cnt_n   = TEMP_LD;
               end else begin
                  state_n = S_DWELL;
                  cnt_n   = dwell_ld;
               end
            end
         end
         S_WAIT_TEMP: begin
            if (abort) begin
               state_n    = S_ERROR;
               err_code_n = ERR_ABORT;
            end else if (heat_ready[cur_idx]) begin
               state_n = S_DWELL;
               cnt_n   = HEAT_LD;
            end else if (!frozen) begin
               if (cnt == '0) begin
                  state_n    = S_ERROR;
                  err_code_n = ERR_TIMEOUT;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
         end
         S_DWELL: begin
            if (abort) begin
               state_n    = S_ERROR;
               err_code_n = ERR_ABORT;
            end else if (!frozen) begin
               if (cnt == '0) begin
                  state_n = S_XFER;
                  stage_n = stage + 4'd1;
                  cnt_n   = XFER_LD;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            stage_n = '0;
         end
         S_ERROR: begin
            if (clr_err) begin
               state_n    = S_IDLE;
               stage_n    = '0;
               err_code_n = ERR_NONE;
            end
         end
         default: begin
            state_n = S_IDLE;
            stage_n = '0;
         end
      endcase
   end

   // Enables are decoded from the next state so the registered outputs line up with the state register.
   always_comb begin
      valve_n  = '0;
      mixer_n  = '0;
      heater_n = '0;
      filter_n = '0;
      case (state_n)
         S_XFER:      if (!frozen) valve_n = 11'(1) << stage_n;
         S_WAIT_TEMP: heater_n[nxt_idx] = 1'b1;
         S_DWELL: begin
            case (stage_kind(stage_n))
               K_MIX:   mixer_n[nxt_idx]     = 1'b1;
               K_FILT:  filter_n[nxt_idx[0]] = 1'b1;
               K_HEAT:  heater_n[nxt_idx]    = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         stage     <= '0;
         cnt       <= '0;
         err_code  <= '0;
         valve_en  <= '0;
         mixer_en  <= '0;
         heater_en <= '0;
         filter_en <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         stage     <= stage_n;
         cnt       <= cnt_n;
         err_code  <= err_code_n;
         valve_en  <= valve_n;
         mixer_en  <= mixer_n;
         heater_en <= heater_n;
         filter_en <= filter_n;
         busy      <= (state_n == S_XFER) || (state_n == S_WAIT_TEMP) || (state_n == S_DWELL);
         done      <= (state_n == S_DONE);
         err       <= (state_n == S_ERROR);
      end
   end
endmodule

// File: tb/tb_synthetic2_flow_sequencer.sv
// Bench for synthetic2_flow_sequencer: per-cycle output timeline built from the stage table, plus literal spot checks.
module tb_synthetic2_flow_sequencer;
   localparam int XF = 2, MX = 3, HT = 4, FL = 2, TO = 5;

   logic        clk = 1'b0;
   logic        rst, start, abort, clr_err;
`ifdef SYN2_SEQ_PAUSE_EN
   logic        pause;
`endif
   logic [3:0]  heat_ready;
   logic [10:0] valve_en;
   logic [3:0]  mixer_en, heater_en, stage;
   logic [1:0]  filter_en, err_code;
   logic        busy, done, err;

   synthetic2_flow_sequencer #(
      .CNT_W(16), .XFER_CYCLES(XF), .MIX_CYCLES(MX), .HEAT_CYCLES(HT),
      .FILTER_CYCLES(FL), .TEMP_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_err(clr_err),
`ifdef SYN2_SEQ_PAUSE_EN
      .pause(pause),
`endif
      .heat_ready(heat_ready), .valve_en(valve_en), .mixer_en(mixer_en),
      .heater_en(heater_en), .filter_en(filter_en), .stage(stage), .busy(busy),
      .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] valve;
      logic [3:0]  mixer;
      logic [3:0]  heater;
      logic [1:0]  filter;
      logic [3:0]  stage;
      logic        busy;
      logic        done;
      logic        err;
      logic [1:0]  code;
   } vec_t;

   vec_t exp_q[$];
   int   tests = 0, fails = 0;
   int   wait_len[11], dwell_len[11];
   int   cyc = 0, busy_cnt = 0, done_cyc = -1, t0 = 0;

   // Stage table: 0 mixer, 1 filter, 2 heater, 3 dispense.
   function automatic int kind_of(input int s);
      case (s)
         0, 2, 5, 8: return 0;
         1, 6:       return 1;
         3, 4, 7, 9: return 2;
         default:    return 3;
      endcase
   endfunction

   function automatic int dev_of(input int s);
      case (s)
         0: return 0;  2: return 1;  5: return 2;  8: return 3;
         1: return 0;  6: return 1;
         3: return 0;  7: return 1;  4: return 2;  9: return 3;
         default: return 0;
      endcase
   endfunction

   task automatic set_defaults();
      for (int s = 0; s < 11; s++) begin
         wait_len[s] = (kind_of(s) == 2) ? 1 : 0;
         case (kind_of(s))
            0: dwell_len[s] = MX;
            1: dwell_len[s] = FL;
            2: dwell_len[s] = HT;
            default: dwell_len[s] = 0;
         endcase
      end
   endtask

   task automatic push_stage(input int s);
      vec_t v;
      v = '0;
      v.busy  = 1'b1;
      v.stage = 4'(s);
      v.valve = 11'(1) << s;
      repeat (XF) exp_q.push_back(v);
      if (s == 10) return;
      v.valve = '0;
      if (kind_of(s) == 2) begin
         v.heater = 4'(1) << dev_of(s);
         repeat (wait_len[s]) exp_q.push_back(v);
      end
      case (kind_of(s))
         0: v.mixer  = 4'(1) << dev_of(s);
         1: v.filter = 2'(1) << dev_of(s);
         default: ;
      endcase
      repeat (dwell_len[s]) exp_q.push_back(v);
   endtask

   task automatic push_idle(input int n);
      vec_t v;
      v = '0;
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic push_error(input int s, input int code, input int n);
      vec_t v;
      v = '0;
      v.err   = 1'b1;
      v.stage = 4'(s);
      v.code  = 2'(code);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic push_full_run();
      vec_t v;
      for (int s = 0; s <= 10; s++) push_stage(s);
      v = '0;
      v.done  = 1'b1;
      v.stage = 4'd10;
      exp_q.push_back(v);
      push_idle(2);
   endtask

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got=%0d want=%0d @%0t", name, got, want, $time);
      end
   endtask

   // Returns at E0+2 where E0 is the edge that samples start.
   task automatic do_start();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      t0       = cyc;
      busy_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout got=%0d pending want=0", name, exp_q.size());
         exp_q.delete();
      end
      #2;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cyc = cyc;
   end

   always @(negedge clk) begin
      vec_t e, a;
      if (rst === 1'b0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {valve_en, mixer_en, heater_en, filter_en, stage, busy, done, err, err_code};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL cycle_vec @%0t got valve=%03h mix=%h heat=%h filt=%h stage=%0d busy=%b done=%b err=%b code=%0d want valve=%03h mix=%h heat=%h filt=%h stage=%0d busy=%b done=%b err=%b code=%0d",
                     $time, a.valve, a.mixer, a.heater, a.filter, a.stage, a.busy, a.done, a.err, a.code,
                     e.valve, e.mixer, e.heater, e.filter, e.stage, e.busy, e.done, e.err, e.code);
         end
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog expired @%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; clr_err = 1'b0; heat_ready = 4'hF;
`ifdef SYN2_SEQ_PAUSE_EN
      pause = 1'b0;
`endif
      @(posedge clk); #1;
      check("rst_valve", int'(valve_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err_code", int'(err_code), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      push_idle(2);
      wait_idle("post_reset");

      // Nominal run, all heaters ready.
      set_defaults();
      do_start();
      push_full_run();
      n = 0;
      foreach (exp_q[i]) if (exp_q[i].busy) n++;
      check("model_busy_len", n, 58);
      wait_idle("nominal");
      check("nominal_done_edge", done_cyc - t0 + 1, 59);
      check("nominal_busy_cycles", busy_cnt, 58);

      // Heater1 never ready: timeout at stage 3.
      set_defaults();
      heat_ready = 4'b1110;
      wait_len[3]  = TO;
      dwell_len[3] = 0;
      do_start();
      for (int s = 0; s <= 3; s++) push_stage(s);
      push_error(3, 1, 3);
      repeat (21) @(posedge clk);
      #2;
      check("timeout_err", int'(err), 1);
      check("timeout_code", int'(err_code), 1);
      check("timeout_stage", int'(stage), 3);
      start = 1'b1;
      repeat (2) @(posedge clk);
      #2 start = 1'b0; clr_err = 1'b1;
      @(posedge clk);
      #2 clr_err = 1'b0;
      push_idle(2);
      wait_idle("timeout");
      heat_ready = 4'hF;

      // Heater3 becomes ready in the third WAIT_TEMP cycle of stage 4.
      set_defaults();
      heat_ready  = 4'b1011;
      wait_len[4] = 3;
      do_start();
      push_full_run();
      repeat (25) @(posedge clk);
      #2 heat_ready = 4'hF;
      wait_idle("late_ready");
      check("late_done_edge", done_cyc - t0 + 1, 61);
      check("late_busy_cycles", busy_cnt, 60);

      // Abort in stage 5 dwell; start and a second abort are ignored in ERROR.
      set_defaults();
      dwell_len[5] = 1;
      do_start();
      for (int s = 0; s <= 5; s++) push_stage(s);
      push_error(5, 2, 4);
      repeat (30) @(posedge clk);
      #2 abort = 1'b1; start = 1'b1;
      @(posedge clk);
      #2 abort = 1'b0;
      check("abort_mixer", int'(mixer_en), 0);
      check("abort_code", int'(err_code), 2);
      @(posedge clk);
      #2 abort = 1'b1;
      @(posedge clk);
      #2 abort = 1'b0;
      @(posedge clk);
      #2 clr_err = 1'b1;
      @(posedge clk);
      #2 clr_err = 1'b0; start = 1'b0;
      push_idle(2);
      wait_idle("abort");

      // Asynchronous reset in the stage 1 transfer, then a clean run.
      set_defaults();
      do_start();
      push_stage(0);
      repeat (5) @(posedge clk);
      #2;
      check("pre_rst_valve", int'(valve_en), 2);
      #1 rst = 1'b1;
      #1;
      check("async_rst_valve", int'(valve_en), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_stage", int'(stage), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      set_defaults();
      do_start();
      push_full_run();
      wait_idle("after_rst");
      check("after_rst_done_edge", done_cyc - t0 + 1, 59);

`ifdef SYN2_SEQ_PAUSE_EN
      // Ten-cycle pause in the Filter1 dwell.
      set_defaults();
      dwell_len[1] = FL + 10;
      do_start();
      push_full_run();
      repeat (7) @(posedge clk);
      #2 pause = 1'b1;
      repeat (10) @(posedge clk);
      #2 pause = 1'b0;
      wait_idle("pause");
      check("pause_done_edge", done_cyc - t0 + 1, 69);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
